rib_arbiter: RTL and testbench
==============================

Name: rib_arbiter

Overview:
- Resource-interconnect bus (RIB) block between the core top level and the memory and peripheral slaves.
- Arbitrates three masters (JTAG debug, core data port, core instruction fetch) onto up to NUM_SLAVES slaves.
- Decodes the slave region from the address and returns read data, ack and error to the owning master.
- Drives the core's RIB hold flag while a core access is outstanding.

Parameters:
NUM_SLAVES, 4, number of slave regions; region index = addr[31:28]; legal range 1..16
TIMEOUT, 255, max cycles waiting for slave ack before bus error; legal range 1..65535

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
m0_req_i  in  1  JTAG master request, held until ack/err
m0_we_i  in  1  JTAG write enable
m0_addr_i  in  32  JTAG address
m0_wdata_i  in  32  JTAG write data
m1_req_i  in  1  core data request (rreq|wreq), held until ack/err
m1_we_i  in  1  core data write enable
m1_addr_i  in  32  core data address
m1_wdata_i  in  32  core data write data
m2_req_i  in  1  instruction fetch request, read-only, held until ack/err
m2_addr_i  in  32  fetch address
m_rdata_o  out  32  shared read-data register, valid in ack cycle
m_ack_o  out  3  per-master completion pulse, bit n = master n
m_err_o  out  3  per-master bus-error pulse
m2_addr_o  out  32  address of the completed fetch, valid with m_ack_o[2]
hold_flag_o  out  1  stall request to core (feeds rib_hold_flag_i)
s_req_o  out  NUM_SLAVES  one-hot slave request, held until that slave acks
s_we_o  out  1  write enable to slaves
s_addr_o  out  32  {4'b0, addr[27:0]}
s_wdata_o  out  32  write data
s_rdata_i  in  32*NUM_SLAVES  slave read data, slave k at bits [32k+31:32k]
s_ack_i  in  NUM_SLAVES  slave completion, one cycle

Behaviour:
- Reset (rst_i high at a clock edge) applies from the next cycle:
  - state IDLE, all outputs 0, timeout counter 0.
  - An in-flight transaction is abandoned: no ack/err is issued and s_req_o drops.
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE:
  - Sample requests with fixed priority m0 > m1 > m2.
  - Latch owner, we (forced 0 for m2), addr, wdata.
  - If addr[31:28] >= NUM_SLAVES, go to ERR. Otherwise go to BUSY with s_req_o[region] = 1.
  - With no request, stay in IDLE.
- BUSY:
  - s_req_o, s_we_o, s_addr_o and s_wdata_o are held stable from registers.
  - The counter increments each cycle.
  - On s_ack_i[sel]: capture s_rdata_i slice into m_rdata_o, go to DONE, deassert s_req_o.
  - Acks from non-selected slaves are ignored.
  - When the counter reaches TIMEOUT with no ack, go to ERR. If ack and timeout fall in the same cycle, the ack wins.
- DONE: m_ack_o[owner] = 1 for exactly one cycle, then IDLE. For owner m2, m2_addr_o = latched address.
- ERR: m_err_o[owner] = 1 for one cycle, m_rdata_o = 0, then IDLE.
- Latency: request sampled in cycle 0 → s_req_o in cycle 1 → with a same-cycle slave ack, m_ack_o in cycle 2. Minimum 2 cycles; back-to-back throughput 1 transfer per 3 cycles.
- Request fields are sampled only in IDLE:
  - Master changes while BUSY have no effect.
  - A request dropped mid-transaction is still completed and acked.
- Writes: m_rdata_o keeps its previous value; only the ack pulses.
- m_rdata_o holds its last captured value until the next capture, ERR or reset.
- The counter clears on entry to BUSY; counter width is $clog2(TIMEOUT+1).
- hold_flag_o (combinational) = (m1_req_i & ~m_ack_o[1] & ~m_err_o[1]) | (m2_req_i & ~m_ack_o[2] & ~m_err_o[2]). It is 0 during reset.
- Fixed priority: m2 can starve while m0/m1 request continuously. This is accepted; the core stalls fetch via hold_flag_o.
- Exactly one bit of m_ack_o | m_err_o is high in any cycle, or none.

Test Plan:
- Single read: m1 reads 0x1000_0040; slave1 acks 2 cycles after s_req_o with 0xDEADBEEF → s_addr_o = 0x0000_0040, s_req_o = 4'b0010, m_ack_o = 3'b010 in cycle 4, m_rdata_o = 0xDEADBEEF, hold_flag_o high cycles 0–3.
- Priority: m0, m1, m2 all request in cycle 0 with zero-wait slaves → acks in order m0 (cycle 2), m1 (cycle 5), m2 (cycle 8). m2_addr_o equals m2_addr_i at the m2 ack.
- Decode error: NUM_SLAVES = 4, m0 addr 0x5000_0000 → no s_req_o, m_err_o = 3'b001 in cycle 1, m_rdata_o = 0.
- Timeout: TIMEOUT = 8, slave never acks → s_req_o high 8 cycles, m_err_o[1] pulses, FSM returns to IDLE; an ack arriving on the same cycle as expiry yields m_ack_o instead.
- Write: m1 write 0x0000_0010 data 0x1234_5678 → s_we_o = 1, s_wdata_o = 0x1234_5678; ack issued; m_rdata_o unchanged.
- Reset mid-BUSY: assert rst_i while s_req_o high → s_req_o 0 next cycle, no m_ack_o/m_err_o, FSM IDLE; a subsequent m2 fetch completes normally.

Source files
------------

// File: rtl/rib_arbiter.sv
// RIB arbiter: fixed-priority three-master bus (JTAG > core data > fetch) onto
// NUM_SLAVES address regions selected by addr[31:28], with a per-access ack timeout.
module rib_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m0_req_i,
  input  logic                     m0_we_i,
  input  logic [31:0]              m0_addr_i,
  input  logic [31:0]              m0_wdata_i,
  input  logic                     m1_req_i,
  input  logic                     m1_we_i,
  input  logic [31:0]              m1_addr_i,
  input  logic [31:0]              m1_wdata_i,
  input  logic                     m2_req_i,
  input  logic [31:0]              m2_addr_i,
  output logic [31:0]              m_rdata_o,
  output logic [2:0]               m_ack_o,
  output logic [2:0]               m_err_o,
  output logic [31:0]              m2_addr_o,
  output logic                     hold_flag_o,
  output logic [NUM_SLAVES-1:0]    s_req_o,
  output logic                     s_we_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_wdata_o,
  input  logic [32*NUM_SLAVES-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // state | meaning
  // IDLE  | waiting for a master request
  // BUSY  | slave request outstanding, timeout counter running
  // DONE  | one-cycle ack pulse to owner
  // ERR   | one-cycle error pulse to owner (decode error or timeout)
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [3:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            req_any;
  logic [1:0]      req_owner;
  logic            req_we;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            dec_err;
  logic            ack_sel;
  logic [31:0]     rdata_sel;
  logic            timeout_hit;

  always_comb begin
    req_any   = m0_req_i | m1_req_i | m2_req_i;
    req_owner = 2'd2;
    req_we    = 1'b0;
    req_addr  = m2_addr_i;
    req_wdata = 32'h0;
    if (m0_req_i) begin
      req_owner = 2'd0;
      req_we    = m0_we_i;
      req_addr  = m0_addr_i;
      req_wdata = m0_wdata_i;
    end else if (m1_req_i) begin
      req_owner = 2'd1;
      req_we    = m1_we_i;
      req_addr  = m1_addr_i;
      req_wdata = m1_wdata_i;
    end
    dec_err = {1'b0, req_addr[31:28]} >= 5'(NUM_SLAVES);
  end

  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = 32'h0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (sel_q == 4'(k)) begin
        ack_sel   = s_ack_i[k];
        rdata_sel = s_rdata_i[32*k +: 32];
      end
    end
  end

  // Counter runs 0..TIMEOUT-1 across the BUSY cycles, so s_req_o is up TIMEOUT cycles.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_any) state_d = dec_err ? ERR : BUSY;
      BUSY: begin
        if (ack_sel)          state_d = DONE;
        else if (timeout_hit) state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          owner_d = req_owner;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          sel_d   = req_addr[31:28];
          cnt_d   = '0;
          if (dec_err) rdata_d = 32'h0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (ack_sel) begin
          if (!we_q) rdata_d = rdata_sel;
        end else if (timeout_hit) begin
          rdata_d = 32'h0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      sel_q   <= 4'h0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    m_ack_o   = 3'b000;
    m_err_o   = 3'b000;
    m2_addr_o = 32'h0;
    s_req_o   = '0;
    case (state_q)
      BUSY: begin
        for (int k = 0; k < NUM_SLAVES; k++) s_req_o[k] = (sel_q == 4'(k));
      end
      DONE: begin
        m_ack_o[owner_q] = 1'b1;
        if (owner_q == 2'd2) m2_addr_o = addr_q;
      end
      ERR:     m_err_o[owner_q] = 1'b1;
      default: ;
    endcase
  end

  assign s_we_o    = (state_q == BUSY) & we_q;
  assign s_addr_o  = {4'h0, addr_q[27:0]};
  assign s_wdata_o = wdata_q;
  assign m_rdata_o = rdata_q;

  assign hold_flag_o = ~rst_i & ((m1_req_i & ~m_ack_o[1] & ~m_err_o[1]) |
                                 (m2_req_i & ~m_ack_o[2] & ~m_err_o[2]));

endmodule

// File: tb/tb_rib_arbiter.sv
// Bench for rib_arbiter: directed cases plus random single-master transactions
// predicted by a cycle-count model of the access outcome.
module tb_rib_arbiter;
  localparam int NS = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we, m2_req;
  logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata, m2_addr;
  logic [31:0]   m_rdata, m2_addr_out, s_addr, s_wdata;
  logic [2:0]    m_ack, m_err;
  logic          hold, s_we;
  logic [NS-1:0] s_req, s_ack;
  logic [32*NS-1:0] s_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_rdata;

  always #5 clk = ~clk;

  rib_arbiter #(.NUM_SLAVES(NS), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m2_req_i(m2_req), .m2_addr_i(m2_addr),
    .m_rdata_o(m_rdata), .m_ack_o(m_ack), .m_err_o(m_err), .m2_addr_o(m2_addr_out),
    .hold_flag_o(hold), .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr),
    .s_wdata_o(s_wdata), .s_rdata_i(s_rdata), .s_ack_i(s_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic r);
    if (m == 0) m0_req = r;
    else if (m == 1) m1_req = r;
    else m2_req = r;
  endtask

  task automatic set_fields(input int m, input logic we, input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin m0_we = we; m0_addr = a; m0_wdata = d; end
    else if (m == 1) begin m1_we = we; m1_addr = a; m1_wdata = d; end
    else m2_addr = a;
  endtask

  // Called at the start of an IDLE cycle; returns at the start of the next IDLE cycle.
  // dly = cycles from s_req_o rising to the slave ack; dly >= TO means no ack.
  task automatic run_txn(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int dly, input logic [31:0] sdata,
                         input logic drop, input logic stray);
    int       region;
    logic     derr, weff, ok, req_on;
    int       done;
    logic [3:0] exp_sreq;
    region   = int'(addr[31:28]);
    derr     = (region >= NS);
    weff     = (m != 2) && we;
    ok       = !derr && dly >= 0 && dly < TO;
    done     = derr ? 1 : (ok ? 2 + dly : 1 + TO);
    exp_sreq = derr ? 4'h0 : 4'(1 << region);
    req_on   = 1'b1;
    set_fields(m, we, addr, wdata);
    set_req(m, 1'b1);
    for (int k = 0; k < NS; k++) s_rdata[32*k +: 32] = $urandom;
    if (!derr) s_rdata[32*region +: 32] = sdata;
    for (int c = 0; c <= done; c++) begin
      if (c > 0) cyc();
      s_ack = '0;
      if (ok && c == 1 + dly) s_ack[region] = 1'b1;
      else if (stray && !derr && c >= 1 && c < done)
        s_ack[(region + 1 + $urandom_range(0, 2)) % NS] = 1'b1;
      if (c == 2 && c < done) begin
        set_fields(m, 1'($urandom), $urandom, $urandom);
        if (drop) begin req_on = 1'b0; set_req(m, 1'b0); end
      end
      #1;
      chk("hold", 32'(hold), 32'((m != 0) && req_on && c != done));
      chk("s_req", 32'(s_req), (c >= 1 && c < done) ? 32'(exp_sreq) : 32'h0);
      if (c == 1 && !derr) begin
        chk("s_addr", s_addr, {4'h0, addr[27:0]});
        chk("s_we", 32'(s_we), 32'(weff));
        if (weff) chk("s_wdata", s_wdata, wdata);
      end
      chk("m_ack", 32'(m_ack), (c == done && ok) ? 32'(1 << m) : 32'h0);
      chk("m_err", 32'(m_err), (c == done && !ok) ? 32'(1 << m) : 32'h0);
      if (c == done) begin
        if (!ok) mdl_rdata = 32'h0;
        else if (!weff) mdl_rdata = sdata;
        chk("m_rdata", m_rdata, mdl_rdata);
        if (ok && m == 2) chk("m2_addr", m2_addr_out, addr);
      end
    end
    set_req(m, 1'b0);
    s_ack = '0;
    cyc();
  endtask

  initial begin
    logic r1, r2;
    logic [2:0] exp_ack;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    m2_req = 0; m2_addr = 0;
    s_rdata = '0; s_ack = '0;
    mdl_rdata = 32'h0;
    cyc();
    m1_req = 1'b1;
    cyc();
    chk("rst_hold", 32'(hold), 32'h0);
    chk("rst_s_req", 32'(s_req), 32'h0);
    chk("rst_ack", 32'(m_ack), 32'h0);
    chk("rst_err", 32'(m_err), 32'h0);
    chk("rst_rdata", m_rdata, 32'h0);
    m1_req = 1'b0;
    rst = 1'b0;
    cyc();

    run_txn(1, 1'b0, 32'h1000_0040, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
    run_txn(0, 1'b0, 32'h5000_0000, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    run_txn(1, 1'b0, 32'h2000_0008, 32'h0, TO + 3, 32'h0, 1'b0, 1'b1);
    run_txn(1, 1'b0, 32'h3000_000C, 32'h0, TO - 1, 32'hCAFE_0007, 1'b0, 1'b1);
    run_txn(1, 1'b0, 32'h3000_0010, 32'h0, 0, 32'h5555_AAAA, 1'b0, 1'b0);
    run_txn(1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1, 32'h9999_9999, 1'b0, 1'b0);
    run_txn(2, 1'b1, 32'h1000_0100, 32'h0, 3, 32'h0BAD_F00D, 1'b1, 1'b1);

    // All three masters at once with zero-wait slaves.
    m0_addr = 32'h0000_0100; m0_we = 0;
    m1_addr = 32'h1000_0200; m1_we = 0;
    m2_addr = 32'h2000_0300;
    s_rdata[31:0] = 32'hA0A0_0000; s_rdata[63:32] = 32'hA1A1_0001; s_rdata[95:64] = 32'hA2A2_0002;
    m0_req = 1; m1_req = 1; m2_req = 1;
    r1 = 1; r2 = 1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc();
      s_ack = s_req;
      #1;
      exp_ack = (c == 2) ? 3'b001 : (c == 5) ? 3'b010 : (c == 8) ? 3'b100 : 3'b000;
      chk("prio_ack", 32'(m_ack), 32'(exp_ack));
      chk("prio_hold", 32'(hold), 32'((r1 && c != 5) || (r2 && c != 8)));
      if (c == 2) begin chk("prio_rd0", m_rdata, 32'hA0A0_0000); m0_req = 0; end
      if (c == 5) begin chk("prio_rd1", m_rdata, 32'hA1A1_0001); m1_req = 0; r1 = 0; end
      if (c == 8) begin
        chk("prio_rd2", m_rdata, 32'hA2A2_0002);
        chk("prio_m2addr", m2_addr_out, 32'h2000_0300);
        m2_req = 0; r2 = 0;
      end
    end
    mdl_rdata = 32'hA2A2_0002;
    s_ack = '0;
    cyc();

    // Reset while a slave request is outstanding.
    set_fields(1, 1'b0, 32'h3000_0000, 32'h0);
    m1_req = 1'b1;
    cyc();
    cyc();
    chk("mid_s_req", 32'(s_req), 32'h8);
    rst = 1'b1;
    #1;
    chk("mid_rst_hold", 32'(hold), 32'h0);
    cyc();
    rst = 1'b0;
    m1_req = 1'b0;
    #1;
    chk("post_rst_s_req", 32'(s_req), 32'h0);
    chk("post_rst_ack", 32'(m_ack), 32'h0);
    chk("post_rst_err", 32'(m_err), 32'h0);
    chk("post_rst_rdata", m_rdata, 32'h0);
    mdl_rdata = 32'h0;
    cyc();
    run_txn(2, 1'b0, 32'h0000_0044, 32'h0, 1, 32'h7777_1111, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int m, rg, d;
      m  = $urandom_range(0, 2);
      rg = $urandom_range(0, 5);
      d  = $urandom_range(0, 9);
      run_txn(m, 1'($urandom), {4'(rg), 28'($urandom)}, $urandom, d, $urandom,
              1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
